// File: rtl/intersection_scheduler.sv
// Two-road intersection phase sequencer with pedestrian walk phase and a shared countdown.
// Optional night-flash mode is compiled in with the NIGHT_FLASH_EN macro.
module intersection_scheduler #(
    parameter int CNT_W = 7,
    parameter int MAX_T = 99
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             set_mode,
    input  logic [CNT_W-1:0] t_green,
    input  logic [CNT_W-1:0] t_yellow,
    input  logic [CNT_W-1:0] t_allred,
    input  logic [CNT_W-1:0] t_walk,
    input  logic             side_car,
    input  logic             ped_req,
    input  logic             night,
    output logic [2:0]       main_ryg,
    output logic [2:0]       side_ryg,
    output logic             walk,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       phase
);

    typedef enum logic [2:0] {
        ST_MG    = 3'd0,
        ST_MY    = 3'd1,
        ST_AR1   = 3'd2,
        ST_WALK  = 3'd3,
        ST_SG    = 3'd4,
        ST_SY    = 3'd5,
        ST_AR2   = 3'd6,
        ST_FLASH = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_T);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    function automatic logic [CNT_W-1:0] clamp_dur(input logic [CNT_W-1:0] d);
        if (d == '0)
            return ONE_C;
        else if (d > MAX_C)
            return MAX_C;
        else
            return d;
    endfunction

    state_t           state_reg, state_next, end_state;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             side_pend_reg, side_pend_next;
    logic             ped_pend_reg, ped_pend_next;
    logic [CNT_W-1:0] dur_green, dur_yellow, dur_allred, dur_walk;
    logic [CNT_W-1:0] dur_cur, dur_end;

`ifdef NIGHT_FLASH_EN
    logic flash_reg, flash_next;
`else
    logic unused_night;
    assign unused_night = night;
`endif

    assign dur_green  = clamp_dur(t_green);
    assign dur_yellow = clamp_dur(t_yellow);
    assign dur_allred = clamp_dur(t_allred);
    assign dur_walk   = clamp_dur(t_walk);

    // Phase that follows the current one when its countdown expires.
    always_comb begin
        end_state = state_reg;
        case (state_reg)
            ST_MG:   end_state = (side_pend_reg || ped_pend_reg) ? ST_MY : ST_MG;
            ST_MY:   end_state = ST_AR1;
            ST_AR1:  end_state = ped_pend_reg ? ST_WALK : ST_SG;
            ST_WALK: end_state = side_pend_reg ? ST_SG : ST_AR2;
            ST_SG:   end_state = ST_SY;
            ST_SY:   end_state = ST_AR2;
            ST_AR2:  end_state = ST_MG;
            default: end_state = state_reg;
        endcase
    end

    always_comb begin
        dur_cur = '0;
        case (state_reg)
            ST_MG, ST_SG:   dur_cur = dur_green;
            ST_MY, ST_SY:   dur_cur = dur_yellow;
            ST_AR1, ST_AR2: dur_cur = dur_allred;
            ST_WALK:        dur_cur = dur_walk;
            default:        dur_cur = '0;
        endcase
    end

    always_comb begin
        dur_end = '0;
        case (end_state)
            ST_MG, ST_SG:   dur_end = dur_green;
            ST_MY, ST_SY:   dur_end = dur_yellow;
            ST_AR1, ST_AR2: dur_end = dur_allred;
            ST_WALK:        dur_end = dur_walk;
            default:        dur_end = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
`ifdef NIGHT_FLASH_EN
        flash_next = flash_reg;
`endif
        if (!set_mode) begin
`ifdef NIGHT_FLASH_EN
            if (state_reg == ST_FLASH) begin
                if (!night) begin
                    state_next = ST_AR2;
                    count_next = dur_allred;
                end else if (tick) begin
                    flash_next = !flash_reg;
                end
            end else if (night) begin
                state_next = ST_FLASH;
                count_next = '0;
                flash_next = 1'b1;
            end else
`endif
            // A zero count only occurs after reset: load without waiting for a tick.
            if (count_reg == '0) begin
                count_next = dur_cur;
            end else if (tick) begin
                if (count_reg > ONE_C) begin
                    count_next = count_reg - ONE_C;
                end else begin
                    state_next = end_state;
                    count_next = dur_end;
                end
            end
        end
    end

    // Requests always latch; a simultaneous clear loses to the set.
    always_comb begin
        side_pend_next = side_car |
            (side_pend_reg & ~((state_next == ST_SG) && (state_reg != ST_SG)));
        ped_pend_next  = ped_req |
            (ped_pend_reg & ~((state_reg == ST_WALK) && (state_next != ST_WALK)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_MG;
            count_reg     <= '0;
            side_pend_reg <= 1'b0;
            ped_pend_reg  <= 1'b0;
`ifdef NIGHT_FLASH_EN
            flash_reg     <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            side_pend_reg <= side_pend_next;
            ped_pend_reg  <= ped_pend_next;
`ifdef NIGHT_FLASH_EN
            flash_reg     <= flash_next;
`endif
        end
    end

    always_comb begin
        main_ryg = 3'b100;
        side_ryg = 3'b100;
        walk     = 1'b0;
        if (!set_mode) begin
            case (state_reg)
                ST_MG:   main_ryg = 3'b001;
                ST_MY:   main_ryg = 3'b010;
                ST_SG:   side_ryg = 3'b001;
                ST_SY:   side_ryg = 3'b010;
                ST_WALK: walk     = 1'b1;
`ifdef NIGHT_FLASH_EN
                ST_FLASH: begin
                    main_ryg = {1'b0, flash_reg, 1'b0};
                    side_ryg = {flash_reg, 2'b00};
                end
`endif
                default: ;
            endcase
        end
    end

    assign count = count_reg;
    assign phase = state_reg;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed self-checking bench for intersection_scheduler; expected values hand-computed.
module tb_intersection_scheduler;

    localparam int CNT_W = 7;

    logic             clock = 1'b0;
    logic             reset;
    logic             tick;
    logic             set_mode;
    logic [CNT_W-1:0] t_green, t_yellow, t_allred, t_walk;
    logic             side_car, ped_req, night;
    logic [2:0]       main_ryg, side_ryg;
    logic             walk;
    logic [CNT_W-1:0] count;
    logic [2:0]       phase;

    int tests_run    = 0;
    int tests_failed = 0;

    intersection_scheduler #(.CNT_W(CNT_W), .MAX_T(99)) dut (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .set_mode (set_mode),
        .t_green  (t_green),
        .t_yellow (t_yellow),
        .t_allred (t_allred),
        .t_walk   (t_walk),
        .side_car (side_car),
        .ped_req  (ped_req),
        .night    (night),
        .main_ryg (main_ryg),
        .side_ryg (side_ryg),
        .walk     (walk),
        .count    (count),
        .phase    (phase)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("[TB] %s ok (%0d)", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One tick pulse, then three idle clocks (tick every 4 clocks).
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
            step();
            step();
        end
    endtask

    task automatic expect_st(input string tag, input int ph, input int cnt);
        check({tag, ".phase"}, int'(phase), ph);
        check({tag, ".count"}, int'(count), cnt);
    endtask

    task automatic expect_lamps(input string tag, input int m, input int s, input int w);
        check({tag, ".main"}, int'(main_ryg), m);
        check({tag, ".side"}, int'(side_ryg), s);
        check({tag, ".walk"}, int'(walk), w);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_side();
        side_car = 1'b1;
        step();
        side_car = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; set_mode = 1'b0; night = 1'b0;
        side_car = 1'b1; ped_req = 1'b0;
        t_green = 7'd5; t_yellow = 7'd2; t_allred = 7'd1; t_walk = 7'd3;
        #1;
        expect_st("reset", 0, 0);
        expect_lamps("reset", 3'b001, 3'b100, 0);
        step();
        reset = 1'b0;

        // Basic cycle with side_car held high
        step();
        expect_st("load", 0, 5);
        for (int c = 4; c >= 1; c--) begin
            tick_n(1);
            check("basic.mg_count", int'(count), c);
        end
        tick_n(1); expect_st("basic.my", 1, 2); expect_lamps("basic.my", 3'b010, 3'b100, 0);
        tick_n(1); expect_st("basic.my1", 1, 1);
        tick_n(1); expect_st("basic.ar1", 2, 1); expect_lamps("basic.ar1", 3'b100, 3'b100, 0);
        tick_n(1); expect_st("basic.sg", 4, 5); expect_lamps("basic.sg", 3'b100, 3'b001, 0);
        tick_n(5); expect_st("basic.sy", 5, 2); expect_lamps("basic.sy", 3'b100, 3'b010, 0);
        tick_n(2); expect_st("basic.ar2", 6, 1);
        tick_n(1); expect_st("basic.mg", 0, 5);

        // Green extension, then a single-clock side_car pulse
        side_car = 1'b0; t_green = 7'd3;
        do_reset();
        step(); expect_st("ext.load", 0, 3);
        tick_n(3); expect_st("ext.reload1", 0, 3);
        tick_n(3); expect_st("ext.reload2", 0, 3);
        pulse_side();
        tick_n(3); expect_st("ext.my", 1, 2);
        tick_n(2); expect_st("ext.ar1", 2, 1);
        tick_n(1); expect_st("ext.sg", 4, 3);
        tick_n(3); expect_st("ext.sy", 5, 2);
        tick_n(2); expect_st("ext.ar2", 6, 1);
        tick_n(1); expect_st("ext.mg", 0, 3);
        tick_n(3); expect_st("ext.side_cleared", 0, 3);

        // Pedestrian request pulse
        ped_req = 1'b1; step(); ped_req = 1'b0;
        tick_n(3); expect_st("ped.my", 1, 2);
        tick_n(2); expect_st("ped.ar1", 2, 1);
        tick_n(1); expect_st("ped.walk", 3, 3); expect_lamps("ped.walk", 3'b100, 3'b100, 1);
        tick_n(1); expect_st("ped.walk2", 3, 2);
        tick_n(1); expect_st("ped.walk1", 3, 1);
        tick_n(1); expect_st("ped.ar2", 6, 1); expect_lamps("ped.ar2", 3'b100, 3'b100, 0);
        tick_n(1); expect_st("ped.mg", 0, 3);
        tick_n(3); expect_st("ped.cleared", 0, 3);

        // Duration clamps
        t_green = 7'd0;
        do_reset();
        step(); expect_st("clamp.green0", 0, 1);
        tick_n(1); expect_st("clamp.green0_ext", 0, 1);
        pulse_side();
        t_yellow = 7'd120;
        tick_n(1); expect_st("clamp.yellow120", 1, 99);

        // set_mode freeze with a side request latched while frozen
        t_green = 7'd5; t_yellow = 7'd2;
        do_reset();
        step(); expect_st("freeze.load", 0, 5);
        tick_n(2); expect_st("freeze.pre", 0, 3);
        set_mode = 1'b1;
        step(); expect_lamps("freeze.lamps", 3'b100, 3'b100, 0);
        tick_n(10); expect_st("freeze.held", 0, 3);
        pulse_side();
        set_mode = 1'b0;
        tick_n(1); expect_st("freeze.resume2", 0, 2);
        expect_lamps("freeze.release", 3'b001, 3'b100, 0);
        tick_n(1); expect_st("freeze.resume1", 0, 1);
        tick_n(1); expect_st("freeze.my", 1, 2);

        // Asynchronous reset in the middle of SG
        tick_n(2); expect_st("rst.ar1", 2, 1);
        tick_n(1); expect_st("rst.sg", 4, 5);
        tick_n(1); expect_st("rst.sg4", 4, 4);
        #2 reset = 1'b1;
        #1;
        expect_st("rst.async", 0, 0);
        expect_lamps("rst.async", 3'b001, 3'b100, 0);
        reset = 1'b0;
        step(); expect_st("rst.reload", 0, 5);

`ifdef NIGHT_FLASH_EN
        night = 1'b1;
        step(); expect_st("night.flash", 7, 0); expect_lamps("night.lit", 3'b010, 3'b100, 0);
        tick_n(1); expect_lamps("night.dark", 3'b000, 3'b000, 0);
        tick_n(1); expect_lamps("night.lit2", 3'b010, 3'b100, 0);
        night = 1'b0;
        step(); expect_st("night.ar2", 6, 1);
        tick_n(1); expect_st("night.mg", 0, 5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
Phase sequencer for a two-road intersection (main/side) with a pedestrian walk phase. It shares one countdown timer across all phases and loads each phase's duration from the time registers. Road and pedestrian requests are arbitrated at phase boundaries. It sits between the time registers and the lamp/LED outputs, and its count feeds the BCD conversion and 7-segment display path.

Parameters:
CNT_W, 7, width of duration inputs and count output
MAX_T, 99, maximum loadable duration (display limit)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  1-cycle pulse from the divider; one tick = one display second
set_mode  in  1  1 = configuration mode; freezes the sequencer
t_green  in  CNT_W  green duration (both roads)
t_yellow  in  CNT_W  yellow duration
t_allred  in  CNT_W  all-red clearance duration
t_walk  in  CNT_W  pedestrian walk duration
side_car  in  1  side-road vehicle sensor, level
ped_req  in  1  pedestrian button, level or pulse
night  in  1  night-flash request (used only with the optional feature)
main_ryg  out  3  {red, yellow, green} for the main road
side_ryg  out  3  {red, yellow, green} for the side road
walk  out  1  pedestrian walk lamp
count  out  CNT_W  remaining seconds in the current phase
phase  out  3  current state code

Behaviour:
- Reset (asynchronous, active-high):
  - state MG; count = 0
  - side_pend = 0, ped_pend = 0
  - main_ryg = 001, side_ryg = 100, walk = 0
- Duration clamp:
  - duration 0 → 1
  - duration > MAX_T → MAX_T
  - all comparisons are unsigned, CNT_W bits
- States and codes: MG=0, MY=1, AR1=2, WALK=3, SG=4, SY=5, AR2=6, FLASH=7.
- Lamps:
  - MG: main 001, side 100
  - MY: main 010, side 100
  - AR1, AR2, WALK: 100 / 100
  - SG: 100 / 001
  - SY: 100 / 010
  - walk = 1 only in WALK
- Request latches:
  - side_pend is set on any clock where side_car = 1; cleared on entry to SG.
  - ped_pend is set on any clock where ped_req = 1; cleared on exit from WALK.
  - A set and a clear in the same cycle: set wins.
- Load after reset: if count == 0 and not set_mode, the next clock loads the clamped duration of the current state without waiting for tick.
- Countdown:
  - On tick with count > 1: count decrements.
  - On tick with count == 1: the phase ends. The next state is registered and count is loaded with the next state's clamped duration in the same clock.
  - Latency from the terminal tick to the new lamps is 1 clock.
- Transitions at phase end:
  - MG: goes to MY if side_pend or ped_pend; otherwise stays in MG and reloads t_green (green extension).
  - MY → AR1.
  - AR1: goes to WALK if ped_pend, else SG.
  - WALK: goes to SG if side_pend, else AR2.
  - SG → SY → AR2 → MG.
- set_mode = 1:
  - state, count and latches are frozen; ticks are ignored.
  - Lamps are forced to main 100, side 100, walk 0.
  - On release, the sequence resumes from the frozen state and count.
  - Request latches still set during set_mode.
- Tick coinciding with set_mode: the tick is ignored.
- Reset mid-phase: immediate return to the reset values; the first clock after release loads t_green.
- count output equals the internal counter; it is never above MAX_T.

Optional Feature:
Macro NIGHT_FLASH_EN.
- With the macro:
  - night = 1 forces FLASH on the next clock from any state, unless set_mode = 1.
  - In FLASH: count = 0 and walk = 0. Main yellow and side red toggle together on each tick, starting lit on entry (main 010, side 100), then dark (000 / 000).
  - Request latches keep operating.
  - When night falls to 0, the next clock enters AR2 with t_allred loaded, then proceeds to MG.
- Without the macro:
  - The night port exists but is ignored.
  - Code 7 is unreachable; FLASH logic is absent.

Test Plan:
- Basic cycle: reset pulse; t_green=5, t_yellow=2, t_allred=1, t_walk=3; side_car held 1; tick every 4 clocks → phases MG(5) MY(2) AR1(1) SG(5) SY(2) AR2(1) MG. count sequences 5,4,3,2,1 in MG; lamps as specified.
- Green extension: side_car=0, ped_req=0, t_green=3 → phase stays 0 and count reloads 3 after each terminal tick. A one-clock side_car pulse during MG → MY follows at the next MG end.
- Pedestrian: 1-clock ped_req pulse in MG, side_car=0 → MG→MY→AR1→WALK (walk=1, count 3,2,1)→AR2→MG; ped_pend cleared after WALK.
- Clamp/boundary: t_green=0 → MG lasts exactly 1 tick. t_yellow=120 → count loads 99.
- set_mode freeze: assert at MG count=3 for 10 ticks → count stays 3, lamps 100/100. Deassert → count continues 2,1 then MY.
- Reset mid-SG with count=4 → immediate MG lamps and count=0; first clock after release loads t_green. With NIGHT_FLASH_EN: night=1 in SG → phase 7, main yellow toggles per tick; night=0 → AR2 then MG.
